// File: rtl/buzzer_tone_player.sv
// Square-wave note player: programmable half-period and duration, followed by a fixed silent gap.
// One note is played per start request, and done pulses once the note and its gap are over.
module buzzer_tone_player #(
    parameter int unsigned HP_W       = 17,
    parameter int unsigned DUR_W      = 24,
    parameter int unsigned GAP_CYCLES = 32'h4000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [HP_W-1:0]  half_period,
    input  logic [DUR_W-1:0] duration,
    output logic             busy,
    output logic             done,
    output logic             buzzer
);

    localparam int unsigned GapW  = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam bit          NoGap = (GAP_CYCLES == 0);
    localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StTone,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [HP_W-1:0]  tone_cnt_q, tone_cnt_d;
    logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
    logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
    logic             buzzer_q, buzzer_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            hp_q       <= '0;
            dur_q      <= '0;
            tone_cnt_q <= '0;
            dur_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            buzzer_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            dur_q      <= dur_d;
            tone_cnt_q <= tone_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            buzzer_q   <= buzzer_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        dur_d      = dur_q;
        tone_cnt_d = tone_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        buzzer_d   = buzzer_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                buzzer_d = 1'b0;
                if (start && !stop) begin
                    hp_d       = half_period;
                    dur_d      = duration;
                    tone_cnt_d = '0;
                    dur_cnt_d  = '0;
                    gap_cnt_d  = '0;
                    if (duration != '0) begin
                        state_d = StTone;
                    end else if (NoGap) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StGap;
                    end
                end
            end

            StTone: begin
                if (stop) begin
                    state_d  = StIdle;
                    buzzer_d = 1'b0;
                end else begin
                    dur_cnt_d = dur_cnt_q + DUR_W'(1);
                    // hp == 0 is a rest: the output simply never toggles
                    if (hp_q != '0) begin
                        if (tone_cnt_q == hp_q - HP_W'(1)) begin
                            tone_cnt_d = '0;
                            buzzer_d   = ~buzzer_q;
                        end else begin
                            tone_cnt_d = tone_cnt_q + HP_W'(1);
                        end
                    end
                    // End of note silences the pin even if a toggle was due
                    if (dur_cnt_q == dur_q - DUR_W'(1)) begin
                        buzzer_d  = 1'b0;
                        gap_cnt_d = '0;
                        if (NoGap) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StGap;
                        end
                    end
                end
            end

            StGap: begin
                buzzer_d = 1'b0;
                if (stop) begin
                    state_d = StIdle;
                end else if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end

            default: begin
                state_d  = StIdle;
                buzzer_d = 1'b0;
            end
        endcase
    end

    assign busy_d = (state_d != StIdle);

    assign busy   = busy_q;
    assign done   = done_q;
    assign buzzer = buzzer_q;

endmodule
